// File: rtl/down_counter_4bit.sv
// Loadable, enable-gated down counter with terminal-count pulse and optional
// auto-reload from the last loaded start value (periodic tick generator).
module down_counter_4bit #(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count_output,
  output logic             zero,
  output logic             tc_pulse,
  output logic             running
);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_DEC,
    ACT_TERM,
    ACT_WRAP
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;
  logic             run_q,    run_d;

  // Priority: load > enable > hold. A zero count under enable only does
  // anything in auto-reload mode; otherwise it holds (never wraps to all-ones).
  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = ACT_LOAD;
    end else if (enable) begin
      if (count_q > WIDTH'(1))
        action = ACT_DEC;
      else if (count_q == WIDTH'(1))
        action = ACT_TERM;
      else if (AUTO_RELOAD)
        action = ACT_WRAP;
    end
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    run_d    = run_q;
    unique case (action)
      ACT_LOAD: begin
        count_d  = load_value;
        reload_d = load_value;
        run_d    = (load_value != '0);
      end
      ACT_DEC: begin
        count_d = count_q - WIDTH'(1);
      end
      ACT_TERM: begin
        count_d = '0;
        tc_d    = 1'b1;
        run_d   = AUTO_RELOAD;
      end
      ACT_WRAP: begin
        count_d = reload_q;
        run_d   = (reload_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      run_q    <= run_d;
    end
  end

  assign count_output = count_q;
  assign zero         = (count_q == '0);
  assign tc_pulse     = tc_q;
  assign running      = run_q;

endmodule

// File: tb/tb_down_counter_4bit.sv
// Bench for down_counter_4bit: one-shot and auto-reload instances share stimulus
// and are checked every cycle against a behavioural model plus directed literals.
module tb_down_counter_4bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic [3:0] c0, c1;
  logic       z0, z1, t0, t1, r0, r1;

  int checks   = 0;
  int failures = 0;

  int m_cnt [2] = '{0, 0};
  int m_rel [2] = '{0, 0};
  bit m_tc  [2] = '{0, 0};
  bit m_run [2] = '{0, 0};

  int exp_en  [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  int exp_cnt [8] = '{3, 3, 3, 2, 1, 1, 0, 0};
  int exp_tc  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int exp_ar [12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};

  always #5 clk = ~clk;

  down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count_output(c0), .zero(z0), .tc_pulse(t0), .running(r0)
  );

  down_counter_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count_output(c1), .zero(z1), .tc_pulse(t1), .running(r1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: index 0 is one-shot, index 1 is auto-reload.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] <= 0; m_rel[k] <= 0; m_tc[k] <= 0; m_run[k] <= 0;
      end else if (load) begin
        m_cnt[k] <= int'(load_value); m_rel[k] <= int'(load_value);
        m_run[k] <= (load_value != 0); m_tc[k] <= 0;
      end else if (enable && m_cnt[k] >= 2) begin
        m_cnt[k] <= m_cnt[k] - 1; m_tc[k] <= 0;
      end else if (enable && m_cnt[k] == 1) begin
        m_cnt[k] <= 0; m_tc[k] <= 1; m_run[k] <= (k == 1);
      end else if (enable && k == 1) begin
        m_cnt[k] <= m_rel[k]; m_run[k] <= (m_rel[k] != 0); m_tc[k] <= 0;
      end else begin
        m_tc[k] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cnt0", int'(c0), m_cnt[0]);
    chk("zero0", int'(z0), int'(m_cnt[0] == 0));
    chk("tc0", int'(t0), int'(m_tc[0]));
    chk("run0", int'(r0), int'(m_run[0]));
    chk("cnt1", int'(c1), m_cnt[1]);
    chk("zero1", int'(z1), int'(m_cnt[1] == 0));
    chk("tc1", int'(t1), int'(m_tc[1]));
    chk("run1", int'(r1), int'(m_run[1]));
  end

  task automatic step(input logic l, input logic [3:0] v, input logic e);
    load = l; load_value = v; enable = e;
    @(negedge clk);
  endtask

  // Assert reset between edges, confirm immediate effect, release before the edge.
  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt0", int'(c0), 0);
    chk("async_rst_zero0", int'(z0), 1);
    chk("async_rst_run0", int'(r0), 0);
    chk("async_rst_tc0", int'(t0), 0);
    chk("async_rst_cnt1", int'(c1), 0);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cnt", int'(c0), 0);
    chk("rst_zero", int'(z0), 1);
    chk("rst_tc", int'(t0), 0);
    chk("rst_run", int'(r0), 0);
    reset = 1'b0;

    step(1'b1, 4'd5, 1'b1);
    chk("os_load5", int'(c0), 5);
    chk("os_run", int'(r0), 1);
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 4'd0, 1'b1);
      chk("os_seq", int'(c0), i);
      chk("os_tc", int'(t0), int'(i == 0));
      chk("ar_tc", int'(t1), int'(i == 0));
    end
    chk("os_run_fall", int'(r0), 0);
    chk("ar_run_stays", int'(r1), 1);
    step(1'b0, 4'd0, 1'b1);
    chk("os_hold0", int'(c0), 0);
    chk("os_hold_tc", int'(t0), 0);
    chk("ar_reload5", int'(c1), 5);

    step(1'b1, 4'd3, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd0, 1'b1);
      chk("ar_period_cnt", int'(c1), exp_ar[i]);
      chk("ar_period_run", int'(r1), 1);
      pulses += int'(t1);
    end
    chk("ar_pulses", pulses, 3);

    step(1'b1, 4'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'd0, exp_en[i][0]);
      chk("gap_cnt", int'(c0), exp_cnt[i]);
      chk("gap_tc", int'(t0), exp_tc[i]);
    end

    step(1'b1, 4'd15, 1'b1);
    chk("load15", int'(c0), 15);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b1);
    chk("at9", int'(c0), 9);
    step(1'b1, 4'd2, 1'b1);
    chk("prio_load2", int'(c0), 2);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("prio_end0", int'(c0), 0);
    chk("prio_tc", int'(t0), 1);
    step(1'b1, 4'd0, 1'b1);
    chk("load0_cnt", int'(c0), 0);
    chk("load0_zero", int'(z0), 1);
    chk("load0_run", int'(r0), 0);
    chk("load0_tc", int'(t0), 0);

    step(1'b1, 4'd7, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);
    chk("pre_rst4", int'(c0), 4);
    async_reset_pulse();
    chk("post_rst_cnt0", int'(c0), 0);
    chk("post_rst_cnt1", int'(c1), 0);
    step(1'b0, 4'd0, 1'b1);
    chk("post_rst_hold", int'(c1), 0);
    chk("post_rst_tc", int'(t1), 0);

    step(1'b1, 4'd1, 1'b1);
    chk("load1_en", int'(c0), 1);
    step(1'b0, 4'd0, 1'b1);
    chk("load1_end", int'(c0), 0);
    chk("load1_tc", int'(t0), 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset_pulse();
      end else begin
        step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
